// File: rtl/csr_req_seq_if.sv
// CSR request/response bundle: execute-stage request, csr file access, writeback response.
// Latency: none (wiring only).
// Backpressure: req_ready/rsp_ready valid-ready handshakes; csr file side has no flow control.
//
// Modports:
//   slave  - the sequencer (consumes requests, drives the csr file, produces responses)
//   master - the surrounding environment (execute stage, csr file, writeback)
interface csr_req_seq_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    // execute stage -> sequencer
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [CSR_AW-1:0] req_addr;
    logic [4:0]        req_rs1;
    logic [XLEN-1:0]   req_src;
    logic [4:0]        req_rd;

    // sequencer <-> csr file
    logic              csr_we;
    logic [CSR_AW+7:0] csr_instr_31_12;
    logic [XLEN-1:0]   csr_wd;
    logic [XLEN-1:0]   csr_rd;

    // sequencer -> writeback
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1, req_src, req_rd,
        output req_ready,
        output csr_we, csr_instr_31_12, csr_wd,
        input  csr_rd,
        output rsp_valid, rsp_data, rsp_rd, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1, req_src, req_rd,
        input  req_ready,
        input  csr_we, csr_instr_31_12, csr_wd,
        output csr_rd,
        input  rsp_valid, rsp_data, rsp_rd, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/csr_req_seq.sv
// CSR access sequencer: encodes one decoded CSR request onto the csr file port and returns the old value.
// Latency: request accept -> 1 ISSUE cycle -> response valid (illegal funct3 skips ISSUE); one access in flight.
// Backpressure: req_ready low until the response handshakes; rsp_ready low holds RESP indefinitely.
//
// Ports: clk, rst (synchronous, active-high), bus (csr_req_seq_if.slave: req_*, csr_*, rsp_*).
// Optional: define CSR_SEQ_CNT_EN to add cnt_access[31:0] (committed writes) and cnt_err[15:0]
//           (illegal-funct3 requests) output counters.
module csr_req_seq #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    csr_req_seq_if.slave       bus
`ifdef CSR_SEQ_CNT_EN
    ,
    output logic [31:0]        cnt_access,
    output logic [15:0]        cnt_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [CSR_AW+7:0] instr_q;
    logic [XLEN-1:0]   wd_q;
    logic              we_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic [4:0]        rsp_rd_q;
    logic              rsp_err_q;

    logic              req_hs;
    logic              req_legal;
    logic              req_writes;

    assign req_hs    = bus.req_valid && bus.req_ready;
    // funct3 000 and 100 are the only encodings with no CSR op in the low two bits.
    assign req_legal = (bus.req_funct3[1:0] != 2'b00);
    // rw/rwi always write; set/clear variants only write when rs1/uimm is non-zero.
    assign req_writes = (bus.req_funct3[1:0] == 2'b01) || (bus.req_rs1 != 5'd0);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = req_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        // Gating with rst keeps a reset landing on the ISSUE cycle from committing a write.
        bus.csr_we    = (state_q == ISSUE) && we_q && !rst;
    end

    assign bus.csr_instr_31_12 = instr_q;
    assign bus.csr_wd          = wd_q;
    assign bus.rsp_data        = rsp_data_q;
    assign bus.rsp_rd          = rsp_rd_q;
    assign bus.rsp_err         = rsp_err_q;

    // ---------------- request latch / response capture ----------------
    // The csr file port fields are registered at accept so they are valid throughout ISSUE
    // and simply hold afterwards; illegal requests never touch them.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (req_hs) begin
                rsp_rd_q <= bus.req_rd;
                we_q     <= req_legal && req_writes;
                if (req_legal) begin
                    instr_q   <= {bus.req_addr, bus.req_rs1, bus.req_funct3};
                    wd_q      <= bus.req_funct3[2] ? {{(XLEN-5){1'b0}}, bus.req_rs1}
                                                   : bus.req_src;
                    rsp_err_q <= 1'b0;
                end else begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end
            end
            // csr_rd is the pre-write value; it is captured on the same edge the file commits.
            if (state_q == ISSUE) begin
                rsp_data_q <= bus.csr_rd;
            end
        end
    end

`ifdef CSR_SEQ_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_access <= '0;
            cnt_err    <= '0;
        end else begin
            if (bus.csr_we) begin
                cnt_access <= cnt_access + 32'd1;
            end
            if (req_hs && !req_legal) begin
                cnt_err <= cnt_err + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csr_req_seq.sv
// Testbench for csr_req_seq: directed scenarios plus randomized traffic against a transaction model.
// Latency: n/a.
// Backpressure: exercised through randomized and held-low rsp_ready.
module tb_csr_req_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_req_seq_if #(.XLEN(32), .CSR_AW(12)) bus ();

`ifdef CSR_SEQ_CNT_EN
    logic [31:0] cnt_access;
    logic [15:0] cnt_err;
`endif

    csr_req_seq #(.XLEN(32), .CSR_AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CSR_SEQ_CNT_EN
        ,
        .cnt_access (cnt_access),
        .cnt_err    (cnt_err)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] csr_op(input logic [2:0] f3, input logic [31:0] old,
                                           input logic [31:0] operand);
        case (f3[1:0])
            2'b01:   return operand;
            2'b10:   return old | operand;
            2'b11:   return old & ~operand;
            default: return old;
        endcase
    endfunction

    // ---------------- environment csr file ----------------
    logic [31:0] csr_file [4096];
    assign bus.csr_rd = csr_file[bus.csr_instr_31_12[19:8]];
    always @(posedge clk) begin
        if (bus.csr_we) begin
            csr_file[bus.csr_instr_31_12[19:8]] <= csr_op(bus.csr_instr_31_12[2:0],
                csr_file[bus.csr_instr_31_12[19:8]], bus.csr_wd);
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [31:0] ref_mem [4096];
    bit          m_pend = 0;
    int          m_age  = 0;       // clock edges since the request was accepted
    bit          m_legal, m_we, m_err;
    logic [2:0]  m_f3;
    logic [11:0] m_addr;
    logic [4:0]  m_rd;
    logic [31:0] m_wd, m_data;
    logic [19:0] last_instr = '0;
    logic [31:0] last_wd    = '0;
    logic [31:0] m_cnt_acc  = '0;
    logic [15:0] m_cnt_err  = '0;
    bit          just_rst   = 0;
    int          cyc        = 0;
    int          req_hs_cyc = 0;
    int          rsp_hs_cyc = 0;

    always @(negedge clk) begin
        bit issue, exp_rv;
        cyc++;
        if (rst) begin
            chk("csr_we_in_reset", {31'd0, bus.csr_we}, 32'd0);
            m_pend = 0; m_age = 0;
            last_instr = '0; last_wd = '0;
            m_cnt_acc = '0; m_cnt_err = '0;
            just_rst = 1;
        end else begin
            if (just_rst) begin
                chk("rst_rsp_data", bus.rsp_data, 32'd0);
                chk("rst_rsp_rd",   {27'd0, bus.rsp_rd}, 32'd0);
                chk("rst_rsp_err",  {31'd0, bus.rsp_err}, 32'd0);
                just_rst = 0;
            end
            issue  = m_pend && m_legal && (m_age == 1);
            exp_rv = m_pend && (m_age >= (m_legal ? 2 : 1));
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, !m_pend});
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_rv});
            chk("csr_we",    {31'd0, bus.csr_we},    {31'd0, issue && m_we});
            chk("csr_instr", {12'd0, bus.csr_instr_31_12}, {12'd0, last_instr});
            chk("csr_wd",    bus.csr_wd, last_wd);
            if (exp_rv) begin
                chk("rsp_data", bus.rsp_data, m_data);
                chk("rsp_rd",   {27'd0, bus.rsp_rd}, {27'd0, m_rd});
                chk("rsp_err",  {31'd0, bus.rsp_err}, {31'd0, m_err});
            end
`ifdef CSR_SEQ_CNT_EN
            chk("cnt_access", cnt_access, m_cnt_acc);
            chk("cnt_err", {16'd0, cnt_err}, {16'd0, m_cnt_err});
`endif
            // advance the model to the state after the coming edge
            if (!m_pend) begin
                if (bus.req_valid) begin
                    m_pend  = 1; m_age = 1;
                    m_f3    = bus.req_funct3;
                    m_addr  = bus.req_addr;
                    m_rd    = bus.req_rd;
                    m_legal = (m_f3 != 3'b000) && (m_f3 != 3'b100);
                    m_we    = m_legal && ((m_f3 == 3'b001) || (m_f3 == 3'b101) || (bus.req_rs1 != 0));
                    m_wd    = m_f3[2] ? {27'd0, bus.req_rs1} : bus.req_src;
                    req_hs_cyc = cyc;
                    if (m_legal) begin
                        last_instr = {bus.req_addr, bus.req_rs1, bus.req_funct3};
                        last_wd    = m_wd;
                        m_err      = 0;
                    end else begin
                        m_err  = 1;
                        m_data = 0;
                        m_cnt_err++;
                    end
                end
            end else if (exp_rv && bus.rsp_ready) begin
                m_pend = 0;
                rsp_hs_cyc = cyc;
            end else begin
                if (issue) begin
                    m_data = ref_mem[m_addr];
                    if (m_we) begin
                        ref_mem[m_addr] = csr_op(m_f3, ref_mem[m_addr], m_wd);
                        m_cnt_acc++;
                    end
                end
                m_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present a request and wait until it is accepted; returns at posedge+1 with req_valid low.
    task automatic issue_req(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                             input logic [31:0] src, input logic [4:0] rd, input bit keep_valid);
        bit acc;
        int n;
        bus.req_funct3 = f3; bus.req_addr = addr; bus.req_rs1 = rs1;
        bus.req_src = src;   bus.req_rd = rd;     bus.req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        chk("req_accept_timeout", {31'd0, acc}, 32'd1);
        if (!keep_valid) begin
            bus.req_valid  = 1'b0;
            bus.req_funct3 = 3'($urandom); bus.req_addr = 12'($urandom);
            bus.req_rs1 = 5'($urandom); bus.req_src = $urandom; bus.req_rd = 5'($urandom);
        end
    endtask

    // Called at a negedge; completes the response handshake with rsp_ready asserted pct% of cycles.
    task automatic take_rsp(input int pct, output logic [31:0] data, output logic [4:0] rdx,
                            output logic err);
        int n = 0;
        while (!(bus.rsp_valid && bus.rsp_ready) && n < 300) begin
            @(posedge clk); #1;
            bus.rsp_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", {31'd0, (bus.rsp_valid && bus.rsp_ready)}, 32'd1);
        data = bus.rsp_data; rdx = bus.rsp_rd; err = bus.rsp_err;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic send(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [31:0] src, input logic [4:0] rd, input int pct,
                        output logic we, output logic [19:0] instr, output logic [31:0] wd,
                        output logic [31:0] data, output logic [4:0] rdx, output logic err);
        issue_req(f3, addr, rs1, src, rd, 0);
        bus.rsp_ready = ($urandom_range(99) < pct);
        @(negedge clk);
        we = bus.csr_we; instr = bus.csr_instr_31_12; wd = bus.csr_wd;
        take_rsp(pct, data, rdx, err);
    endtask

    // ---------------- main sequence ----------------
    logic        o_we, o_err;
    logic [19:0] o_instr;
    logic [31:0] o_wd, o_data, snap;
    logic [4:0]  o_rd;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            csr_file[i] = '0;
            ref_mem[i]  = '0;
        end
        bus.req_valid = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_rs1 = 0;
        bus.req_src = 0; bus.req_rd = 0; bus.rsp_ready = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_instr", {12'd0, bus.csr_instr_31_12}, 32'd0);
        @(posedge clk); #1;

        // csrrw addr 1, rs1 1, src 3, rd 1
        send(3'b001, 12'h001, 5'd1, 32'h3, 5'd1, 100, o_we, o_instr, o_wd, o_data, o_rd, o_err);
        chk("rw_we", {31'd0, o_we}, 32'd1);
        chk("rw_instr", {12'd0, o_instr}, 32'h00109);
        chk("rw_wd", o_wd, 32'h3);
        chk("rw_data", o_data, 32'h0);
        chk("rw_rd", {27'd0, o_rd}, 32'd1);

        // csrrs with all-ones, then csrrs rs1=0 (read only)
        send(3'b010, 12'h001, 5'd1, 32'hFFFF_FFFF, 5'd2, 100, o_we, o_instr, o_wd, o_data, o_rd, o_err);
        chk("rs_we", {31'd0, o_we}, 32'd1);
        chk("rs_wd", o_wd, 32'hFFFF_FFFF);
        chk("rs_data", o_data, 32'h3);
        send(3'b010, 12'h001, 5'd0, 32'h1234_5678, 5'd3, 100, o_we, o_instr, o_wd, o_data, o_rd, o_err);
        chk("rs0_we", {31'd0, o_we}, 32'd0);
        chk("rs0_data", o_data, 32'hFFFF_FFFF);

        // csrrci uimm 5, then read
        send(3'b111, 12'h001, 5'd5, 32'hDEAD_BEEF, 5'd4, 100, o_we, o_instr, o_wd, o_data, o_rd, o_err);
        chk("rci_we", {31'd0, o_we}, 32'd1);
        chk("rci_wd", o_wd, 32'h5);
        chk("rci_data", o_data, 32'hFFFF_FFFF);
        send(3'b010, 12'h001, 5'd0, 32'h0, 5'd5, 100, o_we, o_instr, o_wd, o_data, o_rd, o_err);
        chk("rci_after", o_data, 32'hFFFF_FFFA);

        // illegal funct3 100
        send(3'b100, 12'h001, 5'd7, 32'h55, 5'd6, 100, o_we, o_instr, o_wd, o_data, o_rd, o_err);
        chk("ill_we", {31'd0, o_we}, 32'd0);
        chk("ill_err", {31'd0, o_err}, 32'd1);
        chk("ill_data", o_data, 32'h0);
`ifdef CSR_SEQ_CNT_EN
        chk("ill_cnt_err", {16'd0, cnt_err}, 32'd1);
        chk("ill_cnt_access", cnt_access, 32'd3);
`endif

        // response held off for 10 cycles with the next request waiting
        issue_req(3'b010, 12'h001, 5'd0, 32'h0, 5'd7, 1);
        bus.req_funct3 = 3'b101; bus.req_addr = 12'h002; bus.req_rs1 = 5'd7; bus.req_rd = 5'd8;
        @(negedge clk);
        @(negedge clk);
        chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        snap = bus.rsp_data;
        chk("bp_data", snap, 32'hFFFF_FFFA);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", bus.rsp_data, snap);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1;
        @(negedge clk);
        @(posedge clk); #1 bus.rsp_ready = 0;
        @(negedge clk);
        chk("bp_accept_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1 bus.req_valid = 0;
        @(negedge clk);
        chk("bp_accept_gap", req_hs_cyc - rsp_hs_cyc, 32'd1);
        take_rsp(100, o_data, o_rd, o_err);
        chk("bp_second_data", o_data, 32'h0);

        // reset landing on the ISSUE cycle of a csrrw
        issue_req(3'b001, 12'h001, 5'd9, 32'h1234_5678, 5'd9, 0);
        rst = 1;
        @(negedge clk);
        chk("rst_issue_we", {31'd0, bus.csr_we}, 32'd0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_after_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_after_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_after_wd", bus.csr_wd, 32'd0);
        @(posedge clk); #1;
        send(3'b010, 12'h001, 5'd0, 32'h0, 5'd1, 100, o_we, o_instr, o_wd, o_data, o_rd, o_err);
        chk("rst_csr_unchanged", o_data, 32'hFFFF_FFFA);

        // randomized traffic, checked continuously by the model
        for (int t = 0; t < 250; t++) begin
            send(3'($urandom), 12'($urandom_range(3)),
                 ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, 5'($urandom), 20 + $urandom_range(80),
                 o_we, o_instr, o_wd, o_data, o_rd, o_err);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csr_req_seq.md
Name: csr_req_seq

Overview:
- Initiator side of the CSR file access interface. Accepts decoded CSR requests from the execute stage over a valid/ready handshake.
- Encodes each request into the csr file's instruction-field / write-enable / write-data interface and samples the old CSR value.
- Returns that value with its destination register index over a second valid/ready handshake for writeback.
- Only one access is outstanding at a time.

Parameters:
XLEN, 32, data width of CSR values and rs1 operand
CSR_AW, 12, CSR address width (instr bits 31:20)

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_funct3  input  3  CSR op: 001 rw, 010 rs, 011 rc, 101 rwi, 110 rsi, 111 rci
req_addr  input  CSR_AW  CSR address
req_rs1  input  5  rs1 index, or uimm for immediate ops
req_src  input  XLEN  rs1 register value (ignored for immediate ops)
req_rd  input  5  destination register index
csr_we  output  1  write enable to csr file
csr_instr_31_12  output  20  {addr, rs1/uimm, funct3} to csr file
csr_wd  output  XLEN  write operand to csr file
csr_rd  input  XLEN  combinational read data from csr file (pre-write value)
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_data  output  XLEN  old CSR value (0 on error)
rsp_rd  output  5  destination register index
rsp_err  output  1  illegal funct3

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, req_ready=1, csr_we=0, csr_instr_31_12=0, csr_wd=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, latch funct3/addr/rs1/src/rd.
  - Legal funct3 -> ISSUE. funct3 000 or 100 -> RESP with rsp_err=1, rsp_data=0, and no csr_we pulse.
- ISSUE (exactly one cycle):
  - csr_instr_31_12 = {addr, rs1, funct3}.
  - csr_wd = src for funct3[2]=0; zero-extended 5-bit rs1 (uimm) for funct3[2]=1.
  - csr_we=1, except for rs/rc/rsi/rci with rs1 field==0, where csr_we=0 (no write side effect).
  - rw/rwi always write, including when rd==0.
  - csr_rd is sampled into rsp_data at the same edge the csr file commits its write, so the response carries the pre-write value.
  - Next state is RESP.
- Outside ISSUE: csr_we=0. csr_instr_31_12 and csr_wd hold their last values.
- RESP:
  - rsp_valid=1. rsp_data, rsp_rd and rsp_err are stable while rsp_valid & !rsp_ready.
  - On rsp_ready -> IDLE. rsp_valid falls the next cycle.
- req_ready=0 in ISSUE and RESP. There is no same-cycle response-to-request bypass, so minimum issue spacing is 3 cycles.
- Backpressure: rsp_ready held low stalls in RESP indefinitely. No further csr_we is issued.
- Reset mid-operation:
  - rst in ISSUE: csr_we is forced to 0 in that cycle and no write commits.
  - rst in RESP: the pending response is dropped.
- Set/clear combining is performed inside the csr file. This block only encodes the request and gates the write enable.

Optional Feature:
- Macro: CSR_SEQ_CNT_EN.
- When defined:
  - Adds output ports cnt_access (32), incremented on every ISSUE cycle with csr_we=1, and cnt_err (16), incremented on every illegal-funct3 request.
  - Both counters reset to 0 on rst and wrap modulo 2^width.
- When undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then csrrw with addr=0x001, rs1=1, src=0x3, rd=1 -> one csr_we pulse, csr_instr_31_12=0x00109, csr_wd=0x3, rsp_data = prior value (0 after reset), rsp_rd=1.
- csrrs with src=0xFFFFFFFF and rs1=1, then csrrs with rs1=0 -> first pulses csr_we with csr_wd=0xFFFFFFFF and returns 0x3; second has csr_we=0 and returns 0xFFFFFFFF.
- csrrci with uimm=5 after the CSR holds 0xFFFFFFFF -> csr_wd=0x00000005, csr_we=1, rsp_data=0xFFFFFFFF; the following read returns 0xFFFFFFFA.
- Illegal funct3=100 -> no csr_we, rsp_err=1, rsp_data=0. With CSR_SEQ_CNT_EN: cnt_err=1 and cnt_access unchanged.
- Hold rsp_ready=0 for 10 cycles with a new request waiting -> rsp fields stable, req_ready=0, no csr_we. After release, the request is accepted 1 cycle after rsp handshake.
- Assert rst during an ISSUE cycle -> csr_we=0 that cycle, CSR value unchanged, all outputs at reset values the next cycle.
